// File: rtl/cacheline_burst_adapter.sv
// Cacheline burst adapter: turns one 256-bit cache line read/write into a
// DATA_W-wide beat burst on one memory arbiter requester port.
module cacheline_burst_adapter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               dfp_addr,
  input  logic                      dfp_read,
  input  logic                      dfp_write,
  input  logic [DATA_W*BEATS-1:0]   dfp_wdata,
  output logic [DATA_W*BEATS-1:0]   dfp_rdata,
  output logic                      dfp_resp,
  output logic [31:0]               bmem_addr,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [DATA_W-1:0]         bmem_wdata,
  input  logic                      bmem_ready,
  input  logic [DATA_W-1:0]         bmem_rdata,
  input  logic [31:0]               bmem_raddr,
  input  logic                      bmem_rvalid
);

  localparam int unsigned     LineW    = DATA_W * BEATS;
  localparam int unsigned     CntW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0]     LineMask = ~(32'(LineW / 8) - 32'd1);
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrBurst,
    StDone
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [31:0]       r_line_addr;
  logic [LineW-1:0]  r_buf;
  logic [LineW-1:0]  r_rdata;
  logic [CntW-1:0]   r_beat;
  logic              w_beat_hit;
  logic              w_last;
  logic [LineW-1:0]  w_rd_line;

  assign w_beat_hit = (r_state == StRdWait) && bmem_rvalid && (bmem_raddr == r_line_addr);
  assign w_last     = (r_beat == LastBeat);
  assign dfp_rdata  = r_rdata;

  // r_buf doubles as the read assembly buffer so dfp_rdata only changes on completion
  always_comb begin
    w_rd_line = r_buf;
    w_rd_line[32'(r_beat) * DATA_W +: DATA_W] = bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (dfp_write) begin
          w_state_d = StWrBurst;
        end else if (dfp_read) begin
          w_state_d = StRdReq;
        end
      end
      StRdReq: begin
        if (bmem_ready) w_state_d = StRdWait;
      end
      StRdWait: begin
        if (w_beat_hit && w_last) w_state_d = StDone;
      end
      StWrBurst: begin
        if (bmem_ready && w_last) w_state_d = StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    unique case (r_state)
      StRdReq: begin
        bmem_read = 1'b1;
        bmem_addr = r_line_addr;
      end
      StWrBurst: begin
        bmem_write = 1'b1;
        bmem_addr  = r_line_addr;
        bmem_wdata = r_buf[32'(r_beat) * DATA_W +: DATA_W];
      end
      StDone: begin
        dfp_resp = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line_addr <= '0;
      r_buf       <= '0;
      r_rdata     <= '0;
      r_beat      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (dfp_write || dfp_read) begin
            r_line_addr <= dfp_addr & LineMask;
            r_beat      <= '0;
          end
          if (dfp_write) r_buf <= dfp_wdata;
        end
        StRdReq: begin
          if (bmem_ready) r_beat <= '0;
        end
        StRdWait: begin
          if (w_beat_hit) begin
            r_buf  <= w_rd_line;
            r_beat <= r_beat + CntW'(1);
            if (w_last) r_rdata <= w_rd_line;
          end
        end
        StWrBurst: begin
          if (bmem_ready) r_beat <= r_beat + CntW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench for cacheline_burst_adapter: stimulus queues expected
// requests, write beats and responses; a negedge monitor pops and compares.
module tb_cacheline_burst_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic [31:0]  bmem_raddr;
  logic         bmem_rvalid;

  cacheline_burst_adapter #(
    .DATA_W (64),
    .BEATS  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_raddr  (bmem_raddr),
    .bmem_rvalid (bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           rd_cycles = 0;
  logic [31:0]  exp_wr_addr = '0;
  logic [255:0] last_line = '0;

  logic [31:0]  q_req[$];
  logic [63:0]  q_wr[$];
  logic [255:0] q_resp[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected DUT output expected none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mkline(input logic [63:0] b0, input logic [63:0] b1,
                                          input logic [63:0] b2, input logic [63:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    if (rst) begin
      if (bmem_read) begin
        rd_cycles++;
        if (q_req.size() == 0) begin
          unexpected("rd_req");
        end else begin
          check("rd_req_addr", {224'd0, bmem_addr}, {224'd0, q_req[0]});
          if (bmem_ready) void'(q_req.pop_front());
        end
      end
      if (bmem_write) begin
        if (q_wr.size() == 0) begin
          unexpected("wr_beat");
        end else begin
          check("wr_beat", {192'd0, bmem_wdata}, {192'd0, q_wr.pop_front()});
        end
        check("wr_addr", {224'd0, bmem_addr}, {224'd0, exp_wr_addr});
      end
      if (dfp_resp) begin
        check("resp_bmem_idle", {254'd0, bmem_read, bmem_write}, 256'd0);
        if (q_resp.size() == 0) begin
          unexpected("dfp_resp");
        end else begin
          check("resp_rdata", dfp_rdata, q_resp.pop_front());
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input int n_stall, input int bad_at);
    logic [31:0] la;
    int          start;
    la = addr & 32'hFFFF_FFE0;
    q_req.push_back(la);
    q_resp.push_back(line);
    last_line  = line;
    start      = rd_cycles;
    dfp_addr   = addr;
    dfp_read   = 1'b1;
    bmem_ready = 1'b0;
    tick();
    for (int i = 0; i < n_stall; i++) tick();
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    check("rd_req_cycles", 256'(rd_cycles - start), 256'(n_stall + 1));
    check("rd_req_dropped", {255'd0, bmem_read}, 256'd0);
    for (int k = 0; k < 4; k++) begin
      if (k == bad_at) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'hDEAD_BEE0;
        bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        check("no_resp_on_bad_tag", {255'd0, dfp_resp}, 256'd0);
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = la;
      bmem_rdata  = line[k*64 +: 64];
      tick();
      if (k < 3) check("no_early_resp", {255'd0, dfp_resp}, 256'd0);
    end
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    check("rd_resp", {255'd0, dfp_resp}, 256'd1);
    dfp_read = 1'b0;
    tick();
    check("rd_resp_pulse", {255'd0, dfp_resp}, 256'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input logic [7:0] pat, input int len, input logic both);
    int k;
    exp_wr_addr = addr & 32'hFFFF_FFE0;
    k = 0;
    for (int i = 0; i < len; i++) begin
      q_wr.push_back(line[k*64 +: 64]);
      if (pat[i]) k++;
    end
    q_resp.push_back(last_line);
    dfp_addr   = addr;
    dfp_wdata  = line;
    dfp_write  = 1'b1;
    dfp_read   = both;
    bmem_ready = 1'b0;
    tick();
    for (int i = 0; i < len; i++) begin
      bmem_ready = pat[i];
      check("wr_active", {255'd0, bmem_write}, 256'd1);
      tick();
    end
    bmem_ready = 1'b0;
    check("wr_resp", {255'd0, dfp_resp}, 256'd1);
    check("wr_low_at_resp", {255'd0, bmem_write}, 256'd0);
    dfp_write = 1'b0;
    dfp_read  = 1'b0;
    tick();
    check("wr_resp_pulse", {255'd0, dfp_resp}, 256'd0);
  endtask

  logic [255:0] l1, l2, l3, l4, l5, l5r, l6;

  initial begin
    rst         = 1'b0;
    dfp_addr    = '0;
    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    dfp_wdata   = '0;
    bmem_ready  = 1'b0;
    bmem_rdata  = '0;
    bmem_raddr  = '0;
    bmem_rvalid = 1'b0;
    l1  = mkline(64'hA0, 64'hA1, 64'hA2, 64'hA3);
    l2  = mkline(64'h1111_0000_0000_00D0, 64'h2222_0000_0000_00D1,
                 64'h3333_0000_0000_00D2, 64'h4444_0000_0000_00D3);
    l3  = mkline(64'hC0C0_0000_0000_0001, 64'hC0C0_0000_0000_0002,
                 64'hC0C0_0000_0000_0003, 64'hC0C0_0000_0000_0004);
    l4  = mkline(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5555_AAAA_5555_AAAA, 64'hAAAA_5555_AAAA_5555);
    l5  = mkline(64'h5000, 64'h5001, 64'h5002, 64'h5003);
    l5r = mkline(64'h7700_0000_0000_0070, 64'h7700_0000_0000_0071,
                 64'h7700_0000_0000_0072, 64'h7700_0000_0000_0073);
    l6  = mkline(64'h6600, 64'h6601, 64'h6602, 64'h6603);

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {214'd0, bmem_read, bmem_write, dfp_resp, bmem_addr, bmem_wdata},
          256'd0);
    check("reset_rdata", dfp_rdata, 256'd0);
    rst = 1'b1;
    tick();

    // 1: plain read, line address drops the low five bits
    do_read(32'h1234_5678, l1, 0, -1);
    // 2: write with one stalled beat; read line must be unchanged by it
    do_write(32'h0000_4000, l2, 8'b0001_1101, 5, 1'b0);
    check("rdata_kept_after_write", dfp_rdata, l1);
    // 3: grant withheld for five cycles
    do_read(32'h0000_8020, l3, 5, -1);
    // 4: foreign-tagged beat between beats 1 and 2
    do_read(32'hCAFE_0040, l4, 0, 2);

    // 5: reset after two accepted write beats, then stray beats in idle
    exp_wr_addr = 32'h0000_9000;
    q_wr.push_back(l5[63:0]);
    q_wr.push_back(l5[127:64]);
    dfp_addr   = 32'h0000_9000;
    dfp_wdata  = l5;
    dfp_write  = 1'b1;
    tick();
    bmem_ready = 1'b1;
    tick();
    tick();
    bmem_ready = 1'b0;
    rst        = 1'b0;
    #1;
    check("abort_ctrl", {214'd0, bmem_read, bmem_write, dfp_resp, bmem_addr, bmem_wdata},
          256'd0);
    check("abort_rdata", dfp_rdata, 256'd0);
    last_line = '0;
    dfp_write = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    bmem_rvalid = 1'b1;
    bmem_raddr  = 32'h0000_A000;
    bmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stray_no_resp", {254'd0, dfp_resp, bmem_read}, 256'd0);
    end
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    check("stray_rdata_kept", dfp_rdata, 256'd0);
    do_read(32'h0000_A000, l5r, 1, -1);

    // 6: read and write together in idle -> write burst
    do_write(32'h0001_0010, l6, 8'b0000_1111, 4, 1'b1);

    repeat (3) tick();
    check("q_req_empty", 256'(q_req.size()), 256'd0);
    check("q_wr_empty", 256'(q_wr.size()), 256'd0);
    check("q_resp_empty", 256'(q_resp.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
